gf2_digit_mul_seq: RTL



---
 rtl/gf2_mul_pkg.sv | 31 +++
 rtl/gf2_digit_mul_seq_clmul.sv | 20 ++
 rtl/gf2_digit_mul_seq.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/gf2_mul_pkg.sv
// Shared types and helpers for the digit-serial GF(2)[x] multiplier and its squarer sibling.
package gf2_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RED  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CLMUL_DIGIT_W = 8;
    localparam int CLMUL_M       = 40;

    // Digit counter width; never below one bit so a single-digit build still has a register.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [CLMUL_DIGIT_W+CLMUL_M-2:0] clmul_digit(
        input logic [CLMUL_DIGIT_W-1:0] d,
        input logic [CLMUL_M-1:0]       b
    );
        logic [CLMUL_DIGIT_W+CLMUL_M-2:0] p;
        p = '0;
        for (int i = 0; i < CLMUL_DIGIT_W; i++) begin
            if (d[i]) p ^= (CLMUL_DIGIT_W+CLMUL_M-1)'(b) << i;
        end
        return p;
    endfunction

endpackage

// File: rtl/gf2_digit_mul_seq_clmul.sv
// Combinational DIGIT_W x M carry-less multiply (AND/XOR only), product DIGIT_W+M-1 bits.
module gf2_clmul_digit
    import gf2_mul_pkg::*;
#(
    parameter int DIGIT_W = 8,
    parameter int M       = 40
) (
    input  logic [DIGIT_W-1:0]   digit,
    input  logic [M-1:0]         b,
    output logic [DIGIT_W+M-2:0] prod
);

    always_comb begin
        prod = '0;
        for (int i = 0; i < DIGIT_W; i++) begin
            if (digit[i]) prod ^= (DIGIT_W+M-1)'(b) << i;
        end
    end

endmodule

// File: rtl/gf2_digit_mul_seq.sv
// Digit-serial carry-less multiplier, LSD first, valid/ready on both sides.
// Define GF2_MUL_REDUCE_EN to add the modular reduction pass (RED state).
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// MUL   | one digit of A per cycle XOR-accumulated into acc
// RED   | one DIGIT_W window of the upper half folded per cycle, MSB first
// DONE  | result presented, held until out_ready
module gf2_digit_mul_seq
    import gf2_mul_pkg::*;
#(
    parameter int                            DIGIT_W    = 8,
    parameter int                            NUM_DIGITS = 5,
    parameter logic [DIGIT_W*NUM_DIGITS-1:0] POLY       = 40'h39
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]     a,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]     b,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [2*DIGIT_W*NUM_DIGITS-1:0]   out_data,
    output logic                              busy
);

    localparam int M     = DIGIT_W * NUM_DIGITS;
    localparam int CNT_W = cnt_width(NUM_DIGITS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_DIGITS - 1);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [M-1:0]          a_reg, b_reg;
    logic [2*M-1:0]        acc;
    logic [DIGIT_W-1:0]    digit;
    logic [DIGIT_W+M-2:0]  pp;
    logic [2*M-1:0]        pp_sh;
    logic                  last;

    assign last = (cnt == LAST);

    always_comb begin
        digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cnt == CNT_W'(i)) digit = a_reg[i*DIGIT_W +: DIGIT_W];
        end
    end

    gf2_clmul_digit #(
        .DIGIT_W (DIGIT_W),
        .M       (M)
    ) u_clmul (
        .digit (digit),
        .b     (b_reg),
        .prod  (pp)
    );

    assign pp_sh = {{(M-DIGIT_W+1){1'b0}}, pp} << (32'(cnt) * DIGIT_W);

`ifdef GF2_MUL_REDUCE_EN
    localparam int IDX_W = $clog2(2*M);
    localparam logic [2*M-1:0] POLY_FULL = {{(M-1){1'b0}}, 1'b1, POLY};

    logic [2*M-1:0]   red_acc;
    logic [IDX_W-1:0] red_idx;

    // Bits must be folded top-down: folding bit k can set lower bits of the same window.
    always_comb begin
        red_acc = acc;
        red_idx = '0;
        for (int j = DIGIT_W - 1; j >= 0; j--) begin
            red_idx = IDX_W'(2*M - DIGIT_W*(32'(cnt) + 1) + j);
            if (red_acc[red_idx]) begin
                red_acc = red_acc ^ (POLY_FULL << (M - DIGIT_W*(32'(cnt) + 1) + j));
            end
        end
    end
`else
    logic poly_unused;
    assign poly_unused = ^POLY;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = MUL;
            MUL: begin
                if (last) begin
`ifdef GF2_MUL_REDUCE_EN
                    state_nxt = RED;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef GF2_MUL_REDUCE_EN
            RED:  if (last) state_nxt = DONE;
`endif
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                MUL: begin
                    acc <= acc ^ pp_sh;
                    cnt <= last ? '0 : cnt + 1'b1;
                end
`ifdef GF2_MUL_REDUCE_EN
                RED: begin
                    acc <= red_acc;
                    cnt <= last ? '0 : cnt + 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = acc;

endmodule
